alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered ALU with valid/ready handshake on input and output. Arithmetic status flags.
//  Optional multi-cycle unsigned multiplier.
//  Next-generation datapath ALU for tile designs; sits between an operand sequencer and a result sink.
//  Sustains one op/cycle under no backpressure.
// PARAMETERS
//  WIDTH  8  operand width in bits (>=4); result is 2*WIDTH bits
// PORTS
//  clk         in   1        clock, rising edge
//  rst         in   1        reset, synchronous, active-high
//  in_valid    in   1        operands/op presented
//  in_ready    out  1        block accepts this cycle (transfer = in_valid & in_ready)
//  in_a        in   WIDTH    operand A
//  in_b        in   WIDTH    operand B
//  in_op       in   4        opcode (see BEHAVIOUR)
//  out_valid   out  1        result held valid
//  out_ready   in   1        sink accepts (transfer = out_valid & out_ready)
//  out_result  out  2*WIDTH  result
//  out_flags   out  4        {N,V,C,Z}
//  out_err     out  1        illegal opcode
//  busy        out  1        multiplier running
// BEHAVIOUR
//  Reset: out_valid=0, out_result=0, out_flags=0, out_err=0, busy=0, FSM=IDLE; in_ready=0 while rst=1.
//  in_ready = !rst & (state==IDLE) & (!out_valid | out_ready). Combinational; no dependence on in_valid.
//  Single-cycle ops: accept at edge k -> out_valid=1 after edge k; latency 1, throughput 1/cycle.
//  Output regs hold stable while out_valid & !out_ready. out_valid drops after a transfer with no new accept.
//  Ops (unsigned unless noted; results zero-extended to 2W unless noted):
//   0 ADD:   {A+B} W+1 bits; C=carry-out, V=signed overflow
//   1 SUB:   A-B, W+1-bit result sign-extended to 2W; C=borrow (A<B); V=signed overflow
//   2 AND, 3 OR, 4 XOR: bitwise, W bits; C=V=0
//   5 SHR:   logical A>>B; 0 when B>=W
//   6 SHL:   ({W'0,A}<<B) in 2W bits; 0 when B>=2W
//   7 SRA:   arithmetic A>>>B, sign-extended to 2W; all sign bits when B>=W
//   8 CMPGTU: 1 if A>B unsigned else 0
//   9 CMPLTS: 1 if A<B signed else 0
//   10 MUL:  see CONFIGURATION
//   11-15:   illegal -> result 0, flags 0, out_err=1; still handshaken with latency 1
//  Flags: Z = (result[W-1:0]==0), except MUL where Z = (full 2W result==0). N = result[W-1], except MUL where N = 0.
//   C=V=0 for shifts and compares.
//  FSM: IDLE -(accept MUL)-> MUL -(counter==WIDTH-1)-> IDLE with out_valid=1.
//   busy=1 and in_ready=0 in MUL.
//  Simultaneous: an output transfer and a new accept in the same cycle are legal; the new result replaces the old.
//  rst mid-MUL: abandon op, FSM=IDLE, outputs take reset values next edge.
// CONFIGURATION
//  ALU_MUL_EN defined:
//   - op 10 = unsigned A*B, 2W result, shift-add, one bit/cycle.
//   - Latency WIDTH+1 edges from accept to out_valid; in_ready=0 meanwhile.
//   - Accept blocked while a previous result is unconsumed.
//   - C=V=0.
//  ALU_MUL_EN undefined:
//   - op 10 illegal (out_err=1).
//   - Multiplier, counter and MUL state absent; busy tied 0.
// STRUCTURE
//  Package alu_pkg:
//   - opcode localparams OP_ADD..OP_MUL (4-bit), flag bit indices FLG_Z=0, FLG_C=1, FLG_V=2, FLG_N=3
//   - FSM state encoding ST_IDLE, ST_MUL
//  Sub-module alu_mul_seq (WIDTH): start, a, b -> done pulse, product[2W-1:0].
//   Instantiated only under ALU_MUL_EN.
//  Combinational op decode/flag logic stays in alu_pipe.
// TESTING (WIDTH=8)
//  ADD A=0xFF,B=0x01, out_ready=1 -> next cycle result=0x0100, Z=1,C=1,V=0,N=0
//  SUB A=0x03,B=0x05 -> result=0xFFFE, C=1,N=1,V=0; SUB 0x80-0x01 -> V=1
//  SHL A=0x81,B=9 -> 0x0200; SHR B=8 -> 0; SRA A=0x80,B=3 -> 0xFFF0
//   op 12 -> result 0, out_err=1
//  Back-to-back ADDs with out_ready low 3 cycles -> out_result stable, in_ready=0; first new accept at the edge where out_ready returns
//  ALU_MUL_EN: MUL 0xFF*0xFF -> busy 8 cycles, out_valid after 9 edges, result=0xFE01, Z=0; MUL x*0 -> Z=1
//  rst asserted 3 cycles into MUL -> next edge out_valid=0, busy=0; in_ready=1 after rst falls

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_pipe datapath.
//   - 4-bit opcode encodings OP_ADD..OP_MUL (opcodes 11..15 are illegal)
//   - bit positions of the status flags inside the {N,V,C,Z} flag vector
//   - encoding of the control FSM states
package alu_pkg;

   localparam logic [3:0] OP_ADD    = 4'd0;
   localparam logic [3:0] OP_SUB    = 4'd1;
   localparam logic [3:0] OP_AND    = 4'd2;
   localparam logic [3:0] OP_OR     = 4'd3;
   localparam logic [3:0] OP_XOR    = 4'd4;
   localparam logic [3:0] OP_SHR    = 4'd5;
   localparam logic [3:0] OP_SHL    = 4'd6;
   localparam logic [3:0] OP_SRA    = 4'd7;
   localparam logic [3:0] OP_CMPGTU = 4'd8;
   localparam logic [3:0] OP_CMPLTS = 4'd9;
   localparam logic [3:0] OP_MUL    = 4'd10;

   localparam int FLG_Z = 0;
   localparam int FLG_C = 1;
   localparam int FLG_V = 2;
   localparam int FLG_N = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential unsigned shift-add multiplier, one multiplier bit
// per clock.
//   clk, rst  clock and synchronous active-high reset (abandons any operation)
//   start     load a/b and begin; ignored by nobody, caller only pulses it when idle
//   a, b      WIDTH-bit unsigned operands
//   done      high during the last step (WIDTH-th cycle after start)
//   product   2*WIDTH-bit product; valid in the cycle done is high
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic                 run_r;
   logic [CW-1:0]        cnt_r;
   logic [2*WIDTH-1:0]   mcand_r;
   logic [WIDTH-1:0]     mplier_r;
   logic [2*WIDTH-1:0]   acc_r;
   logic [2*WIDTH-1:0]   acc_nxt_s;

   // Partial-product accumulate for the current multiplier bit.
   always_comb begin
      acc_nxt_s = acc_r;
      if (mplier_r[0]) begin
         acc_nxt_s = acc_r + mcand_r;
      end else begin
         acc_nxt_s = acc_r;
      end
   end

   // The final step's sum is presented directly so the caller can register
   // it on the same edge that ends the operation.
   assign done    = run_r & (cnt_r == CNT_LAST);
   assign product = acc_nxt_s;

   // Operand shift registers, accumulator and step counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_r    <= 1'b0;
         cnt_r    <= {CW{1'b0}};
         mcand_r  <= {(2*WIDTH){1'b0}};
         mplier_r <= {WIDTH{1'b0}};
         acc_r    <= {(2*WIDTH){1'b0}};
      end else if (start) begin
         run_r    <= 1'b1;
         cnt_r    <= {CW{1'b0}};
         mcand_r  <= {{WIDTH{1'b0}}, a};
         mplier_r <= b;
         acc_r    <= {(2*WIDTH){1'b0}};
      end else if (run_r) begin
         acc_r    <= acc_nxt_s;
         mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
         mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
         cnt_r    <= cnt_r + CNT_ONE;
         run_r    <= ~done;
      end else begin
         run_r    <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes and {N,V,C,Z} flags.
// Single-cycle ops complete with latency 1 at one op per cycle; opcode 10 is
// a WIDTH-step unsigned multiply when built with the macro ALU_MUL_EN, and an
// illegal opcode otherwise.
// Ports:
//   clk, rst                clock, synchronous active-high reset
//   in_valid/in_ready       operand handshake (in_ready is combinational)
//   in_a, in_b, in_op       WIDTH-bit operands, 4-bit opcode
//   out_valid/out_ready     result handshake; outputs held while stalled
//   out_result              2*WIDTH-bit result
//   out_flags               {N,V,C,Z}
//   out_err                 illegal opcode
//   busy                    multiplier running
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic [3:0]           in_op,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_result,
   output logic [3:0]           out_flags,
   output logic                 out_err,
   output logic                 busy
);

   // Shift-amount limits expressed in the width of in_b.
   localparam logic [WIDTH-1:0] LIM_W  = WIDTH'(WIDTH);
   localparam logic [WIDTH-1:0] LIM_2W = WIDTH'(2 * WIDTH);

   logic                 accept_s;
   logic                 idle_s;
   logic                 mul_op_s;
   logic                 mul_done_s;
   logic [2*WIDTH-1:0]   mul_product_s;

   logic [WIDTH:0]       sum_s;
   logic [WIDTH:0]       dif_s;
   logic [2*WIDTH-1:0]   sext_a_s;
   logic [2*WIDTH-1:0]   alu_res_s;
   logic                 alu_c_s;
   logic                 alu_v_s;
   logic                 alu_err_s;
   logic [3:0]           alu_flags_s;
   logic [3:0]           mul_flags_s;

   logic                 valid_nxt_s;
   logic [2*WIDTH-1:0]   result_nxt_s;
   logic [3:0]           flags_nxt_s;
   logic                 err_nxt_s;

`ifdef ALU_MUL_EN
   state_t state_r;
   state_t state_nxt_s;
   logic   mul_start_s;

   assign mul_op_s    = (in_op == OP_MUL);
   assign mul_start_s = accept_s & mul_op_s;

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start_s),
      .a       (in_a),
      .b       (in_b),
      .done    (mul_done_s),
      .product (mul_product_s)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state: leave IDLE on a multiply accept, return when it finishes.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (mul_start_s) begin
               state_nxt_s = ST_MUL;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_MUL: begin
            if (mul_done_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_MUL;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   assign idle_s = (state_r == ST_IDLE);
   assign busy   = (state_r == ST_MUL);
`else
   assign mul_op_s      = 1'b0;
   assign mul_done_s    = 1'b0;
   assign mul_product_s = {(2*WIDTH){1'b0}};
   assign idle_s        = 1'b1;
   assign busy          = 1'b0;
`endif

   assign in_ready = ~rst & idle_s & (~out_valid | out_ready);
   assign accept_s = in_valid & in_ready;

   // Single-cycle datapath: opcode decode, result and carry/overflow.
   // Opcode 10 falls into the illegal branch here; when the multiplier is
   // built it is steered away from this result before it can be used.
   always_comb begin
      sum_s     = {1'b0, in_a} + {1'b0, in_b};
      dif_s     = {1'b0, in_a} - {1'b0, in_b};
      sext_a_s  = {{WIDTH{in_a[WIDTH-1]}}, in_a};
      alu_res_s = {(2*WIDTH){1'b0}};
      alu_c_s   = 1'b0;
      alu_v_s   = 1'b0;
      alu_err_s = 1'b0;
      case (in_op)
         OP_ADD: begin
            alu_res_s = {{(WIDTH-1){1'b0}}, sum_s};
            alu_c_s   = sum_s[WIDTH];
            alu_v_s   = (in_a[WIDTH-1] == in_b[WIDTH-1]) & (sum_s[WIDTH-1] != in_a[WIDTH-1]);
         end
         OP_SUB: begin
            // The borrow bit doubles as the sign of the W+1-bit difference.
            alu_res_s = {{(WIDTH-1){dif_s[WIDTH]}}, dif_s};
            alu_c_s   = dif_s[WIDTH];
            alu_v_s   = (in_a[WIDTH-1] != in_b[WIDTH-1]) & (dif_s[WIDTH-1] != in_a[WIDTH-1]);
         end
         OP_AND: alu_res_s = {{WIDTH{1'b0}}, in_a & in_b};
         OP_OR:  alu_res_s = {{WIDTH{1'b0}}, in_a | in_b};
         OP_XOR: alu_res_s = {{WIDTH{1'b0}}, in_a ^ in_b};
         OP_SHR: begin
            if (in_b >= LIM_W) begin
               alu_res_s = {(2*WIDTH){1'b0}};
            end else begin
               alu_res_s = {{WIDTH{1'b0}}, in_a >> in_b};
            end
         end
         OP_SHL: begin
            if (in_b >= LIM_2W) begin
               alu_res_s = {(2*WIDTH){1'b0}};
            end else begin
               alu_res_s = {{WIDTH{1'b0}}, in_a} << in_b;
            end
         end
         OP_SRA: begin
            if (in_b >= LIM_W) begin
               alu_res_s = {(2*WIDTH){in_a[WIDTH-1]}};
            end else begin
               alu_res_s = $signed(sext_a_s) >>> in_b;
            end
         end
         OP_CMPGTU: alu_res_s = {{(2*WIDTH-1){1'b0}}, (in_a > in_b)};
         OP_CMPLTS: alu_res_s = {{(2*WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
         default:   alu_err_s = 1'b1;
      endcase
   end

   // Status flags for the single-cycle path and for a finished multiply.
   always_comb begin
      alu_flags_s = 4'b0000;
      mul_flags_s = 4'b0000;
      if (alu_err_s) begin
         alu_flags_s = 4'b0000;
      end else begin
         alu_flags_s[FLG_Z] = (alu_res_s[WIDTH-1:0] == {WIDTH{1'b0}});
         alu_flags_s[FLG_C] = alu_c_s;
         alu_flags_s[FLG_V] = alu_v_s;
         alu_flags_s[FLG_N] = alu_res_s[WIDTH-1];
      end
      mul_flags_s[FLG_Z] = (mul_product_s == {(2*WIDTH){1'b0}});
   end

   // Output register next values: load on completion, drop valid after a
   // transfer, otherwise hold everything stable.
   always_comb begin
      valid_nxt_s  = out_valid;
      result_nxt_s = out_result;
      flags_nxt_s  = out_flags;
      err_nxt_s    = out_err;
      if (mul_done_s) begin
         valid_nxt_s  = 1'b1;
         result_nxt_s = mul_product_s;
         flags_nxt_s  = mul_flags_s;
         err_nxt_s    = 1'b0;
      end else if (accept_s) begin
         if (mul_op_s) begin
            // Any previous result is being transferred this cycle.
            valid_nxt_s = 1'b0;
         end else begin
            valid_nxt_s  = 1'b1;
            result_nxt_s = alu_res_s;
            flags_nxt_s  = alu_flags_s;
            err_nxt_s    = alu_err_s;
         end
      end else if (out_valid & out_ready) begin
         valid_nxt_s = 1'b0;
      end else begin
         valid_nxt_s = out_valid;
      end
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_result <= {(2*WIDTH){1'b0}};
         out_flags  <= 4'b0000;
         out_err    <= 1'b0;
      end else begin
         out_valid  <= valid_nxt_s;
         out_result <= result_nxt_s;
         out_flags  <= flags_nxt_s;
         out_err    <= err_nxt_s;
      end
   end

endmodule
